// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write-port arbiter: FSM encodings and
// FIFO sizing helpers. Optional burst mode is selected with FIFO_ARB_BURST_EN.
package fifo_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] STALL = 2'd2;

    function automatic int fifo_depth(input int addr_bits);
        return 1 << addr_bits;
    endfunction

    // Occupancy must represent 0..DEPTH inclusive, hence one bit wider than the address.
    function automatic int level_width(input int addr_bits);
        return addr_bits + 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping,
// reported both one-hot and as an index.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    input  logic             enable,
    output logic [N_REQ-1:0] winner,
    output logic [PTR_W-1:0] winner_idx,
    output logic             valid
);

    logic [PTR_W:0] pos;

    always_comb begin
        winner     = '0;
        winner_idx = '0;
        valid      = 1'b0;
        pos        = '0;
        if (enable) begin
            for (int i = 0; i < N_REQ; i++) begin
                pos = {1'b0, ptr} + (PTR_W+1)'(i);
                if (pos >= (PTR_W+1)'(N_REQ)) begin
                    pos = pos - (PTR_W+1)'(N_REQ);
                end
                if (!valid && req[pos[PTR_W-1:0]]) begin
                    winner[pos[PTR_W-1:0]] = 1'b1;
                    winner_idx             = pos[PTR_W-1:0];
                    valid                  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ producers, with
// grant-time occupancy tracking. Define FIFO_ARB_BURST_EN for multi-beat bursts.
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_BITS  = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic [N_REQ-1:0]            req_i,
    input  logic [N_REQ*DATA_WIDTH-1:0] data_i,
    output logic [N_REQ-1:0]            gnt_o,
    output logic [DATA_WIDTH-1:0]       fifo_data_o,
    output logic                        fifo_w_en_o,
    input  logic                        fifo_r_en_i,
    input  logic                        fifo_empty_i,
    output logic [ADDR_BITS:0]          level_o
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int LVL_W = level_width(ADDR_BITS);
    localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(fifo_depth(ADDR_BITS));

    if (N_REQ < 2 || N_REQ > 16 || MAX_BURST < 1) begin : g_bad_params
        $error("fifo_wr_arbiter: N_REQ must be 2..16 and MAX_BURST >= 1");
    end

    logic             rd;
    logic             can_acc;
    logic [N_REQ-1:0] arb_winner;
    logic [PTR_W-1:0] arb_idx;
    logic             arb_valid;
    logic [N_REQ-1:0] sel_winner;
    logic [PTR_W-1:0] sel_idx;
    logic             sel_valid;
    logic             ptr_adv;
    logic [PTR_W-1:0] ptr_r;
    logic [PTR_W-1:0] ptr_nx;
    logic [LVL_W-1:0] level_r;
    logic [LVL_W-1:0] level_nx;
    logic [1:0]       state_r;
    logic [1:0]       state_nx;

    // A read in the same cycle frees the slot a full FIFO would otherwise deny.
    assign rd      = fifo_r_en_i & ~fifo_empty_i;
    assign can_acc = (level_r < DEPTH_L) || rd;

    rr_arbiter #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_rr (
        .req        (req_i),
        .ptr        (ptr_r),
        .enable     (can_acc),
        .winner     (arb_winner),
        .winner_idx (arb_idx),
        .valid      (arb_valid)
    );

`ifdef FIFO_ARB_BURST_EN
    localparam int BCNT_W = $clog2(MAX_BURST + 1);

    logic              keep;
    logic [BCNT_W-1:0] burst_cnt_r;
    logic [PTR_W-1:0]  owner_r;

    // The owner only keeps the port if it was granted last cycle; any gap ends the burst.
    assign keep       = (|gnt_o) && req_i[owner_r] && can_acc && (burst_cnt_r < BCNT_W'(MAX_BURST));
    assign sel_valid  = keep || arb_valid;
    assign sel_idx    = keep ? owner_r : arb_idx;
    assign sel_winner = keep ? gnt_o : arb_winner;
    assign ptr_adv    = arb_valid && !keep;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            burst_cnt_r <= '0;
            owner_r     <= '0;
        end else if (sel_valid) begin
            burst_cnt_r <= keep ? burst_cnt_r + 1'b1 : BCNT_W'(1);
            owner_r     <= sel_idx;
        end
    end
`else
    assign sel_valid  = arb_valid;
    assign sel_idx    = arb_idx;
    assign sel_winner = arb_winner;
    assign ptr_adv    = arb_valid;
`endif

    assign ptr_nx = (sel_idx == PTR_W'(N_REQ - 1)) ? '0 : sel_idx + 1'b1;

    always_comb begin
        level_nx = level_r;
        case ({sel_valid, rd})
            2'b10:   level_nx = level_r + 1'b1;
            2'b01:   level_nx = level_r - 1'b1;
            default: level_nx = level_r;
        endcase
    end

    always_comb begin
        state_nx = state_r;
        case (state_r)
            IDLE:    if (sel_valid) state_nx = GRANT;
            GRANT: begin
                if (sel_valid)                              state_nx = GRANT;
                else if ((|req_i) && (level_r == DEPTH_L)) state_nx = STALL;
                else                                        state_nx = IDLE;
            end
            STALL: begin
                if (sel_valid)    state_nx = GRANT;
                else if (!(|req_i)) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Data holds its last value when idle; only a grant loads a new payload.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            gnt_o       <= '0;
            fifo_w_en_o <= 1'b0;
            fifo_data_o <= '0;
            ptr_r       <= '0;
            level_r     <= '0;
            state_r     <= IDLE;
        end else begin
            assert (!(sel_valid && !rd && level_r == DEPTH_L));
            assert (!(rd && !sel_valid && level_r == '0));
            gnt_o       <= sel_winner;
            fifo_w_en_o <= sel_valid;
            if (sel_valid) begin
                fifo_data_o <= data_i[sel_idx*DATA_WIDTH +: DATA_WIDTH];
            end
            if (ptr_adv) begin
                ptr_r <= ptr_nx;
            end
            level_r <= level_nx;
            state_r <= state_nx;
        end
    end

    assign level_o = level_r;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a behavioural 16-deep FIFO and a
// payload scoreboard; expectations follow FIFO_ARB_BURST_EN when defined.
module tb_fifo_wr_arbiter;
    import fifo_pkg::*;

    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int AB    = 4;
    localparam int DEPTH = 16;
`ifdef FIFO_ARB_BURST_EN
    localparam int BEATS = 4;
`else
    localparam int BEATS = 1;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  req;
    logic [N*DW-1:0] data;
    logic [N-1:0]  gnt;
    logic [DW-1:0] fifo_data;
    logic          w_en;
    logic          ren;
    logic          fifo_empty;
    logic          fifo_full;
    logic [AB:0]   level;

    logic [DW-1:0] fifo_mem [DEPTH];
    logic [AB-1:0] wp, rp;
    logic [AB:0]   fcnt;
    logic [DW-1:0] fifo_dout;

    int            compared   = 0;
    int            mismatched = 0;
    logic [DW-1:0] sb [$];
    int            prod_seq [N];

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .ADDR_BITS(AB), .MAX_BURST(4)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .req_i        (req),
        .data_i       (data),
        .gnt_o        (gnt),
        .fifo_data_o  (fifo_data),
        .fifo_w_en_o  (w_en),
        .fifo_r_en_i  (ren),
        .fifo_empty_i (fifo_empty),
        .level_o      (level)
    );

    assign fifo_empty = (fcnt == '0);
    assign fifo_full  = (fcnt == (AB+1)'(DEPTH));

    // Stand-in for fifo_sync: registered read data, writes dropped when full.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            wp        <= '0;
            rp        <= '0;
            fcnt      <= '0;
            fifo_dout <= '0;
        end else begin
            if (w_en && !fifo_full) begin
                fifo_mem[wp] <= fifo_data;
                wp           <= wp + 1'b1;
            end
            if (ren && !fifo_empty) begin
                fifo_dout <= fifo_mem[rp];
                rp        <= rp + 1'b1;
            end
            fcnt <= fcnt + (AB+1)'(w_en && !fifo_full) - (AB+1)'(ren && !fifo_empty);
        end
    end

    function automatic logic [DW-1:0] payload(input int k, input int s);
        return {2'(k), 6'(s)};
    endfunction

    function automatic logic [N-1:0] onehot(input int k);
        return N'(1 << k);
    endfunction

    function automatic int rr_seq(input int start, input int j, input int n);
        return (start + j / BEATS) % n;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One clock: drive inputs, sample #1 after the edge, then let producers react to gnt.
    task automatic applyStimulus(input logic [N-1:0] req_v, input logic ren_v,
                                 input logic [N-1:0] exp_gnt, input int exp_level);
        logic          did_rd;
        logic [DW-1:0] exp_data;
        logic [DW-1:0] exp_rd;
        int            ek;
        req      = req_v;
        ren      = ren_v;
        did_rd   = ren_v && !fifo_empty;
        ek       = -1;
        exp_data = '0;
        for (int k = 0; k < N; k++) if (exp_gnt[k]) ek = k;
        if (ek >= 0) exp_data = payload(ek, prod_seq[ek]);
        @(posedge clk);
        #1;
        checkOutput("gnt", 32'(gnt), 32'(exp_gnt));
        checkOutput("w_en", 32'(w_en), 32'(|exp_gnt));
        checkOutput("level", 32'(level), 32'(exp_level));
        checkOutput("no_overflow", 32'(w_en && fifo_full), 32'd0);
        if (ek >= 0) begin
            checkOutput("wr_data", 32'(fifo_data), 32'(exp_data));
            sb.push_back(exp_data);
        end
        if (did_rd) begin
            exp_rd = (sb.size() != 0) ? sb.pop_front() : 'x;
            checkOutput("rd_data", 32'(fifo_dout), 32'(exp_rd));
        end
        for (int k = 0; k < N; k++) begin
            if (gnt[k]) begin
                prod_seq[k]++;
                data[k*DW +: DW] = payload(k, prod_seq[k]);
            end
        end
    endtask

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        req   = 4'b1111;
        ren   = 1'b0;
        for (int k = 0; k < N; k++) begin
            prod_seq[k]      = 0;
            data[k*DW +: DW] = payload(k, 0);
        end

        $display("[TB] reset with all requests high");
        repeat (2) begin
            @(posedge clk);
            #1;
            checkOutput("rst_gnt", 32'(gnt), 32'd0);
            checkOutput("rst_w_en", 32'(w_en), 32'd0);
            checkOutput("rst_level", 32'(level), 32'd0);
        end
        reset = 1'b0;
        #1;
        checkOutput("rel_gnt", 32'(gnt), 32'd0);
        checkOutput("rel_level", 32'(level), 32'd0);

        $display("[TB] all requesting, no reads, fill to 16");
        for (int j = 0; j < 16; j++) applyStimulus(4'b1111, 1'b0, onehot(rr_seq(0, j, 4)), j + 1);
        applyStimulus(4'b1111, 1'b0, 4'b0000, 16);
        checkOutput("stall_state", 32'(dut.state_r), 32'(STALL));
        checkOutput("fifo_full", 32'(fifo_full), 32'd1);

        $display("[TB] one read while full");
        applyStimulus(4'b1111, 1'b1, 4'b0001, 16);
        applyStimulus(4'b1111, 1'b0, 4'b0000, 16);
        for (int j = 0; j < 16; j++) applyStimulus(4'b0000, 1'b1, 4'b0000, 15 - j);
        checkOutput("drain1_empty", 32'(fifo_empty), 32'd1);

        $display("[TB] single requester 2");
        for (int j = 0; j < 6; j++) applyStimulus(4'b0100, 1'b0, 4'b0100, j + 1);
        for (int j = 0; j < 6; j++) applyStimulus(4'b0000, 1'b1, 4'b0000, 5 - j);

        $display("[TB] grant and read together at level 5");
        for (int j = 0; j < 5; j++) applyStimulus(4'b1111, 1'b0, onehot(rr_seq(3, j, 4)), j + 1);
        for (int j = 5; j < 15; j++) begin
            applyStimulus(4'b1111, 1'b1, onehot(rr_seq(3, j, 4)), 5);
            checkOutput("no_empty", 32'(fifo_empty), 32'd0);
        end
        for (int j = 0; j < 5; j++) applyStimulus(4'b0000, 1'b1, 4'b0000, 4 - j);

        $display("[TB] requesters 0 and 1 held");
        for (int j = 0; j < 8; j++) applyStimulus(4'b0011, 1'b0, onehot(rr_seq(0, j, 2)), j + 1);
        for (int j = 0; j < 8; j++) applyStimulus(4'b0000, 1'b1, 4'b0000, 7 - j);
        checkOutput("sb_drained", 32'(sb.size()), 32'd0);
        checkOutput("final_empty", 32'(fifo_empty), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
